// File: rtl/fpu_issue_ctrl.sv
// Issue/completion controller for the FP add/sub, divide and multiply units:
// one transaction at a time, with a start pulse, a watchdog and a registered response.
module fpu_issue_ctrl #(
    parameter int W       = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_funct,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic         add_start,
    output logic         div_start,
    output logic         mul_start,
    output logic         add_sub,
    input  logic         add_done,
    input  logic         div_done,
    input  logic         mul_done,
    input  logic [W-1:0] add_res,
    input  logic [W-1:0] div_res,
    input  logic [W-1:0] mul_res,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [3:0]   out_funct,
    output logic         out_zero,
    output logic         out_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] U_ADD  = 2'd0;
    localparam logic [1:0] U_DIV  = 2'd1;
    localparam logic [1:0] U_MUL  = 2'd2;
    localparam logic [1:0] U_NONE = 2'd3;

    localparam logic [3:0] F_ABS = 4'd5;
    localparam logic [3:0] F_NEG = 4'd7;

    // Maps an opcode onto the execution unit that services it.
    function automatic logic [1:0] unit_of(input logic [3:0] f);
        logic [1:0] u;
        case (f)
            4'd0, 4'd1: u = U_ADD;
            4'd2:       u = U_DIV;
            4'd3:       u = U_MUL;
            default:    u = U_NONE;
        endcase
        return u;
    endfunction

    state_t           state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [3:0]       funct_q, funct_d;
    logic             add_sub_q, add_sub_d;
    logic [2:0]       start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     res_q, res_d;
    logic             err_q, err_d;
    logic             sel_done_s;
    logic [W-1:0]     sel_res_s;

    // Completion strobe and result of the unit owning the current opcode.
    always_comb begin
        sel_done_s = 1'b0;
        sel_res_s  = {W{1'b0}};
        case (unit_of(funct_q))
            U_ADD: begin
                sel_done_s = add_done;
                sel_res_s  = add_res;
            end
            U_DIV: begin
                sel_done_s = div_done;
                sel_res_s  = div_res;
            end
            U_MUL: begin
                sel_done_s = mul_done;
                sel_res_s  = mul_res;
            end
            default: begin
                sel_done_s = 1'b0;
                sel_res_s  = {W{1'b0}};
            end
        endcase
    end

    // Transaction sequencing: next state, captures, start pulse and response.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        funct_d   = funct_q;
        add_sub_d = add_sub_q;
        start_d   = 3'b000;
        cnt_d     = cnt_q;
        res_d     = res_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_a_d    = in_a;
                    op_b_d    = in_b;
                    funct_d   = in_funct;
                    add_sub_d = in_funct[0];
                    // start_q bit order is {mul, div, add}; it is high exactly during ISSUE
                    case (unit_of(in_funct))
                        U_ADD: begin
                            start_d = 3'b001;
                            state_d = ST_ISSUE;
                        end
                        U_DIV: begin
                            start_d = 3'b010;
                            state_d = ST_ISSUE;
                        end
                        U_MUL: begin
                            start_d = 3'b100;
                            state_d = ST_ISSUE;
                        end
                        default: begin
                            state_d = ST_RESP;
                            if (in_funct == F_ABS) begin
                                res_d = {1'b0, in_a[W-2:0]};
                                err_d = 1'b0;
                            end else if (in_funct == F_NEG) begin
                                res_d = {~in_a[W-1], in_a[W-2:0]};
                                err_d = 1'b0;
                            end else begin
                                res_d = {W{1'b0}};
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving in the last watchdog cycle still completes normally.
                if (sel_done_s) begin
                    res_d   = sel_res_s;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = {W{1'b0}};
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_a_q    <= {W{1'b0}};
            op_b_q    <= {W{1'b0}};
            funct_q   <= 4'd0;
            add_sub_q <= 1'b0;
            start_q   <= 3'b000;
            cnt_q     <= {CNT_W{1'b0}};
            res_q     <= {W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            funct_q   <= funct_d;
            add_sub_q <= add_sub_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            err_q     <= err_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_RESP);
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign add_sub    = add_sub_q;
    assign add_start  = start_q[0];
    assign div_start  = start_q[1];
    assign mul_start  = start_q[2];
    assign out_result = res_q;
    assign out_funct  = funct_q;
    assign out_err    = err_q;
    // Sign is ignored so that -0 also reports zero.
    assign out_zero   = (res_q[W-2:0] == {(W-1){1'b0}});

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed, table-driven bench for fpu_issue_ctrl with TIMEOUT=8, plus a mid-WAIT reset sequence.
module tb_fpu_issue_ctrl;

    localparam int W  = 32;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_funct;
    logic [W-1:0] in_a, in_b;
    logic [W-1:0] op_a, op_b;
    logic         add_start, div_start, mul_start, add_sub;
    logic         add_done, div_done, mul_done;
    logic [W-1:0] add_res, div_res, mul_res;
    logic         out_valid, out_ready;
    logic [W-1:0] out_result;
    logic [3:0]   out_funct;
    logic         out_zero, out_err;

    int n_checks = 0;
    int n_pass   = 0;

    fpu_issue_ctrl #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
        .in_a(in_a), .in_b(in_b), .op_a(op_a), .op_b(op_b),
        .add_start(add_start), .div_start(div_start), .mul_start(mul_start),
        .add_sub(add_sub),
        .add_done(add_done), .div_done(div_done), .mul_done(mul_done),
        .add_res(add_res), .div_res(div_res), .mul_res(mul_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_funct(out_funct), .out_zero(out_zero), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // unit: 0 add, 1 div, 2 mul, 3 none; dly: cycles from start to done, -1 = never
    typedef struct {
        logic [3:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        int          dly;
        logic [31:0] ures;
        bit          stray;
        int          bp;
        logic [31:0] exp_res;
        logic        exp_err;
        logic        exp_zero;
        int          exp_lat;
        int          unit;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat = -1;
        int sc = -100;
        int n_add = 0, n_div = 0, n_mul = 0;
        chk(idx, "in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_funct = v.funct; in_a = v.a; in_b = v.b;
        @(negedge clk);
        in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b; in_funct = 4'hF;
        for (int c = 1; c <= 40; c++) begin
            add_done = 1'b0; div_done = 1'b0; mul_done = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
            if (add_start) begin n_add++; sc = c; end
            if (div_start) begin n_div++; sc = c; end
            if (mul_start) begin n_mul++; sc = c; end
            if (v.dly >= 0 && c == sc + v.dly) begin
                case (v.unit)
                    0: begin add_done = 1'b1; add_res = v.ures; end
                    1: begin div_done = 1'b1; div_res = v.ures; end
                    2: begin mul_done = 1'b1; mul_res = v.ures; end
                    default: ;
                endcase
            end
            if (v.stray && c == sc + 1) begin
                if (v.unit != 0) begin add_done = 1'b1; add_res = 32'hDEADBEEF; end
                if (v.unit != 2) begin mul_done = 1'b1; mul_res = 32'hBADC0DE5; end
            end
            @(negedge clk);
        end
        add_done = 1'b0; div_done = 1'b0; mul_done = 1'b0;
        chk(idx, "latency", 32'(lat), 32'(v.exp_lat));
        chk(idx, "n_add_start", 32'(n_add), (v.unit == 0) ? 32'd1 : 32'd0);
        chk(idx, "n_div_start", 32'(n_div), (v.unit == 1) ? 32'd1 : 32'd0);
        chk(idx, "n_mul_start", 32'(n_mul), (v.unit == 2) ? 32'd1 : 32'd0);
        chk(idx, "out_result", out_result, v.exp_res);
        chk(idx, "out_funct", 32'(out_funct), 32'(v.funct));
        chk(idx, "out_err", 32'(out_err), 32'(v.exp_err));
        chk(idx, "out_zero", 32'(out_zero), 32'(v.exp_zero));
        chk(idx, "add_sub", 32'(add_sub), 32'(v.funct[0]));
        chk(idx, "op_a", op_a, v.a);
        chk(idx, "op_b", op_b, v.b);
        for (int k = 0; k < v.bp; k++) begin
            add_done = (k == 1);
            @(negedge clk);
            chk(idx, "bp_out_valid", 32'(out_valid), 32'd1);
            chk(idx, "bp_in_ready", 32'(in_ready), 32'd0);
            chk(idx, "bp_result", out_result, v.exp_res);
            chk(idx, "bp_err", 32'(out_err), 32'(v.exp_err));
        end
        add_done = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk(idx, "post_out_valid", 32'(out_valid), 32'd0);
        chk(idx, "post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        //              funct  a             b             dly ures          st bp exp_res       err   zero  lat unit
        vecs[0] = '{4'd0,  32'h3F800000, 32'h40000000, 3,  32'h40400000, 0, 0, 32'h40400000, 1'b0, 1'b0, 5,  0};
        vecs[1] = '{4'd1,  32'h40400000, 32'h3F800000, 1,  32'h40000000, 0, 0, 32'h40000000, 1'b0, 1'b0, 3,  0};
        vecs[2] = '{4'd5,  32'hC0490FDB, 32'h00000000, -1, 32'h0,        0, 0, 32'h40490FDB, 1'b0, 1'b0, 1,  3};
        vecs[3] = '{4'd7,  32'h00000000, 32'h11111111, -1, 32'h0,        0, 0, 32'h80000000, 1'b0, 1'b1, 1,  3};
        vecs[4] = '{4'd3,  32'h40000000, 32'h40400000, 4,  32'h40C00000, 1, 5, 32'h40C00000, 1'b0, 1'b0, 6,  2};
        vecs[5] = '{4'd4,  32'h12345678, 32'h9ABCDEF0, -1, 32'h0,        0, 0, 32'h00000000, 1'b1, 1'b1, 1,  3};
        vecs[6] = '{4'd2,  32'h40800000, 32'h40000000, -1, 32'h0,        1, 2, 32'h00000000, 1'b1, 1'b1, 10, 1};
        vecs[7] = '{4'd2,  32'h3F800000, 32'h40000000, 8,  32'h3F000000, 0, 0, 32'h3F000000, 1'b0, 1'b0, 10, 1};
        vecs[8] = '{4'd3,  32'h80000000, 32'h3F800000, 2,  32'h80000000, 0, 0, 32'h80000000, 1'b0, 1'b1, 4,  2};
        vecs[9] = '{4'd15, 32'hFFFFFFFF, 32'h0,        -1, 32'h0,        0, 0, 32'h00000000, 1'b1, 1'b1, 1,  3};

        rst_n = 1'b0; in_valid = 1'b0; in_funct = 4'd0; in_a = '0; in_b = '0;
        add_done = 1'b0; div_done = 1'b0; mul_done = 1'b0;
        add_res = '0; div_res = '0; mul_res = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(-1, "rst_in_ready", 32'(in_ready), 32'd1);
        chk(-1, "rst_starts", {29'd0, add_start, div_start, mul_start}, 32'd0);
        chk(-1, "rst_out_valid", 32'(out_valid), 32'd0);
        chk(-1, "rst_out_result", out_result, 32'd0);
        chk(-1, "rst_out_funct", 32'(out_funct), 32'd0);
        chk(-1, "rst_out_zero", 32'(out_zero), 32'd1);
        chk(-1, "rst_out_err", 32'(out_err), 32'd0);
        chk(-1, "rst_op_a", op_a, 32'd0);
        chk(-1, "rst_op_b", op_b, 32'd0);
        chk(-1, "rst_add_sub", 32'(add_sub), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a divide, then a late div_done must be ignored.
        in_valid = 1'b1; in_funct = 4'd2; in_a = 32'h40A00000; in_b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        chk(-1, "mid_div_start", 32'(div_start), 32'd1);
        repeat (3) @(negedge clk);
        chk(-1, "mid_waiting", 32'(in_ready | out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk(-1, "mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk(-1, "mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk(-1, "mid_rst_starts", {29'd0, add_start, div_start, mul_start}, 32'd0);
        chk(-1, "mid_rst_op_a", op_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        div_done = 1'b1; div_res = 32'h40200000;
        @(negedge clk);
        div_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk(-1, "post_rst_out_valid", 32'(out_valid), 32'd0);
            chk(-1, "post_rst_in_ready", 32'(in_ready), 32'd1);
            chk(-1, "post_rst_starts", {29'd0, add_start, div_start, mul_start}, 32'd0);
            @(negedge clk);
        end
        run_vec(10, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Parametrised issue/completion controller in front of the floating-point execution units: adder/subtractor, multiplier and divider. It accepts one operation at a time over a valid/ready handshake and registers the operands. It fires a single-cycle start pulse to the selected unit and waits for that unit's done strobe, with a watchdog timeout. It returns a registered result with status flags over a second valid/ready handshake. It replaces free-running selection muxes with a defined per-operation transaction, so the pipeline stalls on `in_ready`/`out_valid` instead of sampling unfinished results.

## Interface
- `W`, 32: operand/result width; bit W-1 is the sign.
- `TIMEOUT`, 64: maximum WAIT cycles before an operation is aborted; legal range ≥2.
- `CNT_W`, $clog2(TIMEOUT+1): width of the watchdog counter.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  controller can accept a request.
- `in_funct`  in  4  operation code: 0 add, 1 sub, 2 div, 3 mul, 5 abs, 7 neg; every other code is illegal.
- `in_a`, `in_b`  in  W  operands.
- `op_a`, `op_b`  out  W  registered operands driven to all units.
- `add_start`, `div_start`, `mul_start`  out  1  one-cycle start pulses.
- `add_sub`  out  1  registered `in_funct[0]`; 1 selects subtract.
- `add_done`, `div_done`, `mul_done`  in  1  unit completion strobes.
- `add_res`, `div_res`, `mul_res`  in  W  unit results, valid with their done strobe.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  W  registered result.
- `out_funct`  out  4  opcode of the returned result.
- `out_zero`  out  1  `out_result[W-2:0]==0`.
- `out_err`  out  1  illegal opcode or timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, capture `in_a`, `in_b` and `in_funct` into op regs.
  - Opcodes 0/1/2/3 go to ISSUE.
  - Opcodes 5/7 and illegal opcodes go directly to RESP. The result is computed from captured operands in the same edge:
    - abs = {1'b0, a[W-2:0]}
    - neg = {~a[W-1], a[W-2:0]}
    - illegal = 0 with `out_err`=1.
- ISSUE:
  - Assert exactly one start, selected by the opcode (0/1 → add, 2 → div, 3 → mul), for one cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT:
  - Monitor only the selected unit's done strobe.
  - Done from a non-selected unit is ignored.
  - On selected done, register its result with `out_err`=0 and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, register result 0 with `out_err`=1 and go to RESP.
  - If done arrives in the same cycle the counter reaches TIMEOUT, done wins.
- RESP:
  - `out_valid`=1; all out_* stay stable until `out_ready`.
  - On `out_valid`&&`out_ready`, go to IDLE.
  - `in_ready` stays 0 in this state: no request is accepted in the acceptance cycle.
- `op_a`, `op_b` and `add_sub` stay constant from capture until the next accept.
- `out_zero` is derived from the registered result. It is 1 for both +0 and −0.
- Asynchronous reset in any state clears all registers and returns to IDLE. Any operation in flight is discarded.

## Timing
- Reset values:
  - `in_ready`=1.
  - All starts=0.
  - `out_valid`=0.
  - `out_result`=0; `out_funct`=0.
  - `out_zero`=1; `out_err`=0.
  - `op_a`=`op_b`=0; `add_sub`=0.
- Unit ops: accept at edge T, start high during cycle T+1, done sampled from cycle T+2 onward.
  - Done seen in cycle T+1+L (L≥1) gives `out_valid` from cycle T+2+L.
  - Minimum accept-to-result latency is 3 cycles.
- abs/neg/illegal ops: `out_valid` in the cycle after accept (latency 1).
- Timeout: `out_valid` rises TIMEOUT+1 cycles after the start cycle.
- Throughput: at most one operation per (latency + 1) cycles. There is no overlap.

## Test plan
- Reset: assert `rst_n`=0 mid-WAIT. Required response: `out_valid`=0, `in_ready`=1, no start pulse; a later `div_done` is ignored.
- Add: a=0x3F800000, b=0x40000000, funct 0; `add_done` 3 cycles after `add_start` with res 0x40400000. Required response: `add_start` high exactly 1 cycle with `add_sub`=0; `out_result`=0x40400000, `out_funct`=0, `out_err`=0, `out_zero`=0.
- Abs/neg: funct 5 with a=0xC0490FDB gives 0x40490FDB one cycle after accept; funct 7 with a=0x00000000 gives 0x80000000 with `out_zero`=1.
- Backpressure and stray done: mul 2.0×3.0 with `out_ready`=0 for 5 cycles. Required response: 0x40C00000 held stable and `in_ready`=0 throughout; a stray `add_done` during WAIT does not complete the mul.
- Timeout: funct 2 with `div_done` never asserted, TIMEOUT=8. Required response: `out_valid` rises 9 cycles after `div_start`, `out_err`=1, result 0. A second case asserts done in the timeout cycle and requires `out_err`=0.
- Illegal opcode: funct 4. Required response: no start pulse, `out_err`=1, `out_result`=0, `out_funct`=4, latency 1.
